// File: rtl/serial_router_pkg.sv
// ---------------------------------------------------------------------------
// serial_router_pkg
// Shared definitions for the serial port router:
//   state_t     - frame-parser state encoding
//   SEG_ZERO    - seven-segment code shown when nothing is counting
//   hex_to_seg  - 4-bit hex value to seven-segment code (gfedcba, active-high)
// ---------------------------------------------------------------------------
package serial_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PORT  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_ZERO = 7'h3F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/pb_step.sv
// ---------------------------------------------------------------------------
// pb_step
// Turns a raw push-button level into a single one-clock step pulse per
// rising edge, independent of how long the button is held.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   pb     - raw, asynchronous push-button level
//   step   - one-clock pulse, three clocks after pb rises
// ---------------------------------------------------------------------------
module pb_step (
    input  logic clock,
    input  logic reset,
    input  logic pb,
    output logic step
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       armed;
    logic [1:0] settle;

    // The synchronizer flops come out of reset at 0, so their contents do not
    // reflect the button for two clocks.  'settle' waits for them to fill,
    // and 'armed' then requires one observed low level before any edge may
    // count.  A button already held during reset release is therefore ignored
    // until it is released and pressed again.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            armed  <= 1'b0;
            settle <= 2'd0;
            step   <= 1'b0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
            prev  <= sync2;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd2 && !sync2) begin
                armed <= 1'b1;
            end
            step <= armed & sync2 & ~prev;
        end
    end

endmodule

// File: rtl/serial_port_router.sv
// ---------------------------------------------------------------------------
// serial_port_router
// Parses a push-button-clocked serial frame and routes the data phase of the
// frame to one of NUM_PORTS output channels.
//
// Frame (one bit per step, MSB-first fields):
//   start bit 0 | PORT_W port bits | CNT_W length bits | <length> data steps
//
// Ports:
//   clock    - sole clock, rising edge
//   reset    - synchronous, active-high reset
//   clkPB    - raw push-button level, each rising edge is one serial step
//   SerIn    - serial frame bit, sampled only on a step
//   SerOut   - routed data bit per channel (live copy of SerIn on the
//              selected channel during the data phase, 0 elsewhere)
//   valid    - per-channel data-phase indicator
//   display  - seven-segment code of the remaining data count
//   busy     - high whenever a frame is in progress
//   done     - one-clock pulse at frame end
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a start bit (step with SerIn = 0)
// ST_PORT  | shifting in the port address
// ST_COUNT | shifting in the data length
// ST_DATA  | routing SerIn to the selected channel, counting steps down
// ---------------------------------------------------------------------------
module serial_port_router
    import serial_router_pkg::*;
#(
    parameter  int PORT_W    = 2,
    parameter  int CNT_W     = 4,
    localparam int NUM_PORTS = 2 ** PORT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clkPB,
    input  logic                 SerIn,
    output logic [NUM_PORTS-1:0] SerOut,
    output logic [NUM_PORTS-1:0] valid,
    output logic [6:0]           display,
    output logic                 busy,
    output logic                 done
);

    state_t              state;
    logic                step;
    logic [PORT_W-1:0]   port_sr;
    logic [CNT_W-1:0]    len_sr;
    logic [CNT_W-1:0]    remain;
    logic [3:0]          bit_cnt;

    logic [PORT_W-1:0]   port_next;
    logic [CNT_W-1:0]    len_next;
    logic [NUM_PORTS-1:0] port_onehot;

    pb_step u_pb_step (
        .clock (clock),
        .reset (reset),
        .pb    (clkPB),
        .step  (step)
    );

    // Shift-in values including the bit sampled on the current step, so the
    // last field bit can be acted on in the same cycle it arrives.
    assign port_next   = (port_sr << 1) | PORT_W'(SerIn);
    assign len_next    = (len_sr << 1) | CNT_W'(SerIn);
    assign port_onehot = NUM_PORTS'(1) << port_sr;

    // Only the low four bits of the count are shown; narrower counts are
    // zero-extended.
    function automatic logic [6:0] seg_of(input logic [CNT_W-1:0] v);
        return hex_to_seg(4'(v));
    endfunction

    // bit_cnt is a down-counter holding the number of field bits still to
    // come after the current one; terminal count 0 marks the last bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            port_sr <= '0;
            len_sr  <= '0;
            remain  <= '0;
            bit_cnt <= '0;
            valid   <= '0;
            display <= SEG_ZERO;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (step) begin
                case (state)
                    ST_IDLE: begin
                        if (!SerIn) begin
                            state   <= ST_PORT;
                            port_sr <= '0;
                            len_sr  <= '0;
                            bit_cnt <= 4'(PORT_W - 1);
                        end
                    end
                    ST_PORT: begin
                        port_sr <= port_next;
                        if (bit_cnt == 4'd0) begin
                            state   <= ST_COUNT;
                            bit_cnt <= 4'(CNT_W - 1);
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end
                    ST_COUNT: begin
                        len_sr <= len_next;
                        if (bit_cnt == 4'd0) begin
                            if (len_next != '0) begin
                                state   <= ST_DATA;
                                remain  <= len_next;
                                valid   <= port_onehot;
                                display <= seg_of(len_next);
                            end else begin
                                // Empty frame: finishes without a data phase.
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end
                    ST_DATA: begin
                        // remain is never 0 here, so the decrement cannot wrap.
                        remain  <= remain - CNT_W'(1);
                        display <= seg_of(remain - CNT_W'(1));
                        if (remain == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            valid <= '0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign SerOut = valid & {NUM_PORTS{SerIn}};
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_port_router.sv
module tb_serial_port_router;

    logic       clock;
    logic       reset;
    logic       pb_a;
    logic       pb_b;
    logic       SerIn;

    logic [3:0] SerOut_a, valid_a;
    logic [6:0] display_a;
    logic       busy_a, done_a;

    logic [7:0] SerOut_b, valid_b;
    logic [6:0] display_b;
    logic       busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int port;
        int len;
        bit aborted;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Hand-written seven-segment table (gfedcba)
    int segtab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    serial_port_router dut_a (
        .clock   (clock),
        .reset   (reset),
        .clkPB   (pb_a),
        .SerIn   (SerIn),
        .SerOut  (SerOut_a),
        .valid   (valid_a),
        .display (display_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    serial_port_router #(.PORT_W(3), .CNT_W(3)) dut_b (
        .clock   (clock),
        .reset   (reset),
        .clkPB   (pb_b),
        .SerIn   (SerIn),
        .SerOut  (SerOut_b),
        .valid   (valid_b),
        .display (display_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    bit saw_a = 0, prev_done_a = 0;
    bit saw_b = 0, prev_done_b = 0;

    always @(negedge clock) begin
        exp_t e;
        int   mask;
        if (reset) begin
            if (qa.size() > 0 && qa[0].aborted) begin
                check("a_abort_saw_valid", int'(saw_a), 1);
                e = qa.pop_front();
            end
            saw_a = 0;
        end else begin
            if (valid_a != '0) begin
                saw_a = 1;
                if (qa.size() == 0) begin
                    check("a_unexpected_valid", int'(valid_a), 0);
                end else begin
                    mask = 1 << qa[0].port;
                    check("a_valid_mask", int'(valid_a), mask);
                    check("a_serout", int'(SerOut_a), SerIn ? mask : 0);
                end
            end else if (SerOut_a != '0) begin
                check("a_serout_idle", int'(SerOut_a), 0);
            end
            if (done_a) begin
                if (prev_done_a) check("a_done_width", 2, 1);
                if (qa.size() == 0 || qa[0].aborted) begin
                    check("a_unexpected_done", 1, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_frame_had_data", int'(saw_a), int'(e.len != 0));
                    check("a_valid_at_done", int'(valid_a), 0);
                    saw_a = 0;
                end
            end
        end
        prev_done_a = done_a;
    end

    always @(negedge clock) begin
        exp_t e;
        int   mask;
        if (reset) begin
            if (qb.size() > 0 && qb[0].aborted) begin
                check("b_abort_saw_valid", int'(saw_b), 1);
                e = qb.pop_front();
            end
            saw_b = 0;
        end else begin
            if (valid_b != '0) begin
                saw_b = 1;
                if (qb.size() == 0) begin
                    check("b_unexpected_valid", int'(valid_b), 0);
                end else begin
                    mask = 1 << qb[0].port;
                    check("b_valid_mask", int'(valid_b), mask);
                    check("b_serout", int'(SerOut_b), SerIn ? mask : 0);
                end
            end else if (SerOut_b != '0) begin
                check("b_serout_idle", int'(SerOut_b), 0);
            end
            if (done_b) begin
                if (prev_done_b) check("b_done_width", 2, 1);
                if (qb.size() == 0 || qb[0].aborted) begin
                    check("b_unexpected_done", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_frame_had_data", int'(saw_b), int'(e.len != 0));
                    check("b_valid_at_done", int'(valid_b), 0);
                    saw_b = 0;
                end
            end
        end
        prev_done_b = done_b;
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input bit to_b, input int port, input int len, input bit aborted);
        exp_t e;
        e.port    = port;
        e.len     = len;
        e.aborted = aborted;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic press(input bit to_b, input bit b, input int hold);
        @(posedge clock); #1;
        SerIn = b;
        if (to_b) pb_b = 1'b1;
        else      pb_a = 1'b1;
        repeat (hold) @(posedge clock);
        #1;
        pb_a = 1'b0;
        pb_b = 1'b0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic send(input bit to_b, input logic [15:0] vec, input int n);
        for (int i = n - 1; i >= 0; i--) press(to_b, vec[i], 5);
    endtask

    initial begin
        logic [4:0] data_bits;
        reset = 1'b1;
        pb_a  = 1'b0;
        pb_b  = 1'b0;
        SerIn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid_a", int'(valid_a), 0);
        check("rst_serout_a", int'(SerOut_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_done_a", int'(done_a), 0);
        check("rst_display_a", int'(display_a), 'h3F);
        check("rst_busy_b", int'(busy_b), 0);
        check("rst_display_b", int'(display_b), 'h3F);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;

        // Steps with SerIn=1 in IDLE are ignored
        for (int i = 0; i < 3; i++) begin
            press(0, 1'b1, 5);
            check("idle_ones_busy", int'(busy_a), 0);
        end

        // Port 3, length 5
        push_exp(0, 3, 5, 0);
        press(0, 1'b0, 5);
        check("start_busy", int'(busy_a), 1);
        send(0, 16'b011_0101, 6);
        check("len5_display", int'(display_a), 'h6D);
        data_bits = 5'b10110;
        for (int k = 1; k <= 5; k++) begin
            press(0, data_bits[5-k], 5);
            check("data_display", int'(display_a), segtab[5-k]);
        end
        check("after_frame_busy", int'(busy_a), 0);

        // Port 1, length 0
        push_exp(0, 1, 0, 0);
        send(0, 16'b001_0000, 7);
        check("len0_busy", int'(busy_a), 0);
        check("len0_display", int'(display_a), 'h3F);

        // Reset mid data phase
        push_exp(0, 2, 3, 1);
        send(0, 16'b010_0011, 7);
        check("len3_display", int'(display_a), segtab[3]);
        press(0, 1'b1, 5);
        press(0, 1'b0, 5);
        check("abort_pre_display", int'(display_a), segtab[1]);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_valid", int'(valid_a), 0);
        check("abort_serout", int'(SerOut_a), 0);
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_display", int'(display_a), 'h3F);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        push_exp(0, 0, 1, 0);
        send(0, 16'b000_0001, 7);
        check("post_abort_display", int'(display_a), segtab[1]);
        press(0, 1'b1, 5);
        check("post_abort_busy", int'(busy_a), 0);

        // Long hold gives exactly one step: port 2, length 1
        push_exp(0, 2, 1, 0);
        press(0, 1'b0, 5);
        press(0, 1'b1, 50);
        press(0, 1'b0, 5);
        send(0, 16'b0001, 4);
        check("hold_display", int'(display_a), segtab[1]);
        press(0, 1'b0, 5);
        check("hold_busy", int'(busy_a), 0);

        // Button held through reset release produces no step
        pb_a  = 1'b1;
        SerIn = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("pb_high_release_busy", int'(busy_a), 0);
        pb_a = 1'b0;
        repeat (8) @(posedge clock);
        #1;

        // Wide instance: port 5, length 2
        push_exp(1, 5, 2, 0);
        send(1, 16'b0101_010, 7);
        check("b_len2_display", int'(display_b), 'h5B);
        check("b_busy", int'(busy_b), 1);
        press(1, 1'b1, 5);
        check("b_display_1", int'(display_b), 'h06);
        press(1, 1'b0, 5);
        check("b_display_0", int'(display_b), 'h3F);
        check("b_busy_end", int'(busy_b), 0);

        repeat (5) @(posedge clock);
        #1;
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
